// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - instruction fetch sequencer with decoupling instruction queue
module ifetch_queue #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [0:63] redirect_pc,
  input  logic        halt_req,
  output logic        mem_rd_en,
  output logic [0:60] mem_rd_addr,
  input  logic [0:63] mem_rd_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [0:31] out_instr,
  output logic [0:63] out_pc,
  output logic [0:63] fetch_pc
);

  // Pointer width indexes DEPTH entries; the count needs one extra bit to hold DEPTH itself.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  // Occupancy (count + inflight) can reach DEPTH, compared at CW+1 bits.
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);
  localparam logic [0:63] RESET_PC_ALIGNED = RESET_PC & ~64'h3;

  // Fetch sequencing state
  logic [0:63]   r_fetch_pc;
  logic          r_inflight;
  logic [0:63]   r_inflight_pc;

  // Queue state
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [0:31]   r_q_instr [DEPTH];
  logic [0:63]   r_q_pc    [DEPTH];

  // Combinational controls
  logic [CW:0]   w_occupancy;
  logic          w_issue;
  logic          w_push;
  logic          w_pop;
  logic          w_out_valid;
  logic [0:31]   w_push_instr;
  logic [0:63]   w_fetch_pc_inc;
  logic [0:63]   w_redirect_target;

  // Slots already spoken for: queued entries plus the one fetch whose data is still coming back.
  // A same-cycle pop is deliberately not credited, keeping issue independent of out_ready.
  assign w_occupancy = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};

  // Redirect and reset suppress issue outright; halt only stops new requests.
  assign w_issue = !rst && !redirect_valid && !halt_req && (w_occupancy < DEPTH_W);

  // Returning data is dropped whenever the stream is being flushed in this cycle.
  assign w_push = r_inflight && !rst && !redirect_valid;

  assign w_out_valid = !rst && (r_count != '0);
  assign w_pop       = w_out_valid && out_ready && !redirect_valid;

  // Bit 61 of the byte address picks the word within the doubleword (big-endian: [0:31] is the lower address).
  assign w_push_instr = r_inflight_pc[61] ? mem_rd_data[32:63] : mem_rd_data[0:31];

  assign w_fetch_pc_inc    = r_fetch_pc + 64'd4;
  assign w_redirect_target = redirect_pc & ~64'h3;

  assign mem_rd_en   = w_issue;
  assign mem_rd_addr = r_fetch_pc[0:60];
  assign fetch_pc    = r_fetch_pc;

  // Head is read straight from queue storage; zeros are shown while the queue is empty.
  assign out_valid = w_out_valid;
  assign out_instr = w_out_valid ? r_q_instr[r_rd_ptr] : 32'h0;
  assign out_pc    = w_out_valid ? r_q_pc[r_rd_ptr]    : 64'h0;

  // Fetch PC and in-flight tracking; reset beats redirect, redirect beats issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC_ALIGNED;
      r_inflight    <= 1'b0;
      r_inflight_pc <= 64'h0;
    end else if (redirect_valid) begin
      r_fetch_pc    <= w_redirect_target;
      r_inflight    <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_fetch_pc    <= w_fetch_pc_inc;
        r_inflight_pc <= r_fetch_pc;
      end
    end
  end

  // Queue pointers and occupancy; a flush empties the queue regardless of push or pop.
  always_ff @(posedge clk) begin
    if (rst || redirect_valid) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue storage write at the tail; contents need no reset since out_valid gates the head.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_instr[r_wr_ptr] <= w_push_instr;
      r_q_pc[r_wr_ptr]    <= r_inflight_pc;
    end
  end

endmodule
